// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy change dispenser driving a coin hopper over req/ack
module change_dispenser #(
    parameter int W       = 8,
    parameter int INIT_50 = 4,
    parameter int INIT_10 = 8,
    parameter int INIT_5  = 8,
    parameter int INIT_1  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] change,
    input  logic         refill,
    input  logic [1:0]   refill_sel,
    input  logic [3:0]   refill_cnt,
    output logic         coin_req,
    output logic [1:0]   coin_sel,
    input  logic         coin_ack,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [W-1:0] remaining,
    output logic [3:0]   empty
);

    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, DONE, FAIL} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] stock [4];
    logic [1:0] pick;
    logic       pick_ok;
    logic [4:0] refill_sum;
    logic [3:0] refill_sat;

    function automatic logic [W-1:0] coin_value(input logic [1:0] d);
        case (d)
            2'd0:    return W'(50);
            2'd1:    return W'(10);
            2'd2:    return W'(5);
            default: return W'(1);
        endcase
    endfunction

    // Scan smallest to largest so the largest affordable, stocked coin wins.
    always_comb begin
        pick_ok = 1'b0;
        pick    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (coin_value(2'(i)) <= remaining && stock[i] != 4'd0) begin
                pick_ok = 1'b1;
                pick    = 2'(i);
            end
        end
    end

    assign refill_sum = {1'b0, stock[refill_sel]} + {1'b0, refill_cnt};
    assign refill_sat = refill_sum[4] ? 4'hF : refill_sum[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = SELECT;
            SELECT: begin
                if (remaining == '0) state_nx = DONE;
                else if (pick_ok)    state_nx = DISPENSE;
                else                 state_nx = FAIL;
            end
            DISPENSE: if (coin_ack) state_nx = SELECT;
            DONE:     state_nx = IDLE;
            FAIL:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        coin_req = (state == DISPENSE);
        busy     = (state != IDLE);
        done     = (state == DONE);
        fail     = (state == FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_sel  <= 2'd0;
            remaining <= '0;
            stock[0]  <= 4'(INIT_50);
            stock[1]  <= 4'(INIT_10);
            stock[2]  <= 4'(INIT_5);
            stock[3]  <= 4'(INIT_1);
        end else begin
            case (state)
                IDLE: begin
                    if (start)  remaining <= change;
                    if (refill) stock[refill_sel] <= refill_sat;
                end
                SELECT: begin
                    if (remaining != '0 && pick_ok) coin_sel <= pick;
                end
                DISPENSE: begin
                    if (coin_ack) begin
                        remaining       <= remaining - coin_value(coin_sel);
                        stock[coin_sel] <= stock[coin_sel] - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) empty[i] = (stock[i] == 4'd0);
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - table-driven bench for change_dispenser
module tb_change_dispenser;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance 0: defaults, 1: INIT_50=0, 2: INIT_5=0 INIT_1=2
    logic [2:0]      start_v, refill_v, ack_v, coin_req_v, busy_v, done_v, fail_v;
    logic [2:0][7:0] change_v, remaining_v;
    logic [2:0][1:0] refill_sel_v, coin_sel_v;
    logic [2:0][3:0] refill_cnt_v, empty_v;

    change_dispenser dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .change(change_v[0]),
        .refill(refill_v[0]), .refill_sel(refill_sel_v[0]), .refill_cnt(refill_cnt_v[0]),
        .coin_req(coin_req_v[0]), .coin_sel(coin_sel_v[0]), .coin_ack(ack_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]),
        .remaining(remaining_v[0]), .empty(empty_v[0]));

    change_dispenser #(.INIT_50(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .change(change_v[1]),
        .refill(refill_v[1]), .refill_sel(refill_sel_v[1]), .refill_cnt(refill_cnt_v[1]),
        .coin_req(coin_req_v[1]), .coin_sel(coin_sel_v[1]), .coin_ack(ack_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]),
        .remaining(remaining_v[1]), .empty(empty_v[1]));

    change_dispenser #(.INIT_5(0), .INIT_1(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .change(change_v[2]),
        .refill(refill_v[2]), .refill_sel(refill_sel_v[2]), .refill_cnt(refill_cnt_v[2]),
        .coin_req(coin_req_v[2]), .coin_sel(coin_sel_v[2]), .coin_ack(ack_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .fail(fail_v[2]),
        .remaining(remaining_v[2]), .empty(empty_v[2]));

    typedef struct {
        int          dut;
        int          change;
        int          ack_delay;
        bit          hold_start;
        bit          refill;
        logic [3:0]  refill_cnt;
        bit          exp_fail;
        int          exp_rem;
        int          exp_n;
        logic [31:0] exp_seq;
        logic [3:0]  exp_empty;
    } vec_t;

    vec_t tbl[10];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int          held = 0;
        int          ncoin = 0;
        int          first_evt = -1;
        int          cyc = 2;
        logic [31:0] seq = '0;
        logic [1:0]  first_sel = 2'd0;
        bit          got_done = 0;
        bit          got_fail = 0;
        int          d = v.dut;

        @(negedge clk);
        start_v[d]      = 1'b1;
        change_v[d]     = 8'(v.change);
        refill_v[d]     = v.refill;
        refill_sel_v[d] = 2'd3;
        refill_cnt_v[d] = v.refill_cnt;
        @(posedge clk);
        @(negedge clk);
        refill_v[d] = 1'b0;
        if (!v.hold_start) start_v[d] = 1'b0;
        chk("select_busy", int'(busy_v[d]), 1);
        chk("select_no_req", int'(coin_req_v[d]), 0);
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (first_evt < 0 && (coin_req_v[d] || done_v[d] || fail_v[d])) first_evt = cyc;
            if (d == 1) chk("b_empty50", int'(empty_v[1][0]), 1);
            if (done_v[d]) begin got_done = 1; break; end
            if (fail_v[d]) begin got_fail = 1; break; end
            if (coin_req_v[d]) begin
                if (held == 0) first_sel = coin_sel_v[d];
                else chk("sel_stable", int'(coin_sel_v[d]), int'(first_sel));
                held++;
                if (held == v.ack_delay) begin
                    if (ncoin < 16) seq[2*ncoin +: 2] = coin_sel_v[d];
                    ncoin++;
                    ack_v[d] = 1'b1;
                end else begin
                    ack_v[d] = 1'b0;
                end
            end else begin
                held = 0;
                ack_v[d] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        ack_v[d] = 1'b0;
        chk("first_event_cycle", first_evt, 2);
        chk("got_done", int'(got_done), int'(!v.exp_fail));
        chk("got_fail", int'(got_fail), int'(v.exp_fail));
        chk("coin_count", ncoin, v.exp_n);
        chk("coin_seq", int'(seq), int'(v.exp_seq));
        chk("remaining", int'(remaining_v[d]), v.exp_rem);
        @(posedge clk);
        @(negedge clk);
        chk("pulse_done_width", int'(done_v[d]), 0);
        chk("pulse_fail_width", int'(fail_v[d]), 0);
        chk("busy_after", int'(busy_v[d]), 0);
        chk("empty", int'(empty_v[d]), int'(v.exp_empty));
    endtask

    task automatic do_refill(input int d, input logic [1:0] sel, input logic [3:0] cnt);
        @(negedge clk);
        refill_v[d] = 1'b1;
        refill_sel_v[d] = sel;
        refill_cnt_v[d] = cnt;
        @(posedge clk);
        @(negedge clk);
        refill_v[d] = 1'b0;
        chk("refill_idle", int'(busy_v[d]), 0);
    endtask

    initial begin
        //          dut chg dly hold rfl cnt  fail rem n   seq           empty
        tbl[0] = '{0, 67, 1, 0, 0, 4'd0, 0, 0, 5,  32'h3E4,   4'b0000};
        tbl[1] = '{1, 60, 1, 0, 0, 4'd0, 0, 0, 6,  32'h555,   4'b0001};
        tbl[2] = '{2, 8,  1, 0, 0, 4'd0, 1, 6, 2,  32'hF,     4'b1100};
        tbl[3] = '{0, 10, 4, 0, 0, 4'd0, 0, 0, 1,  32'h1,     4'b0000};
        tbl[4] = '{0, 0,  1, 1, 0, 4'd0, 0, 0, 0,  32'h0,     4'b0000};
        tbl[5] = '{2, 9,  1, 0, 0, 4'd0, 0, 0, 9,  32'h3FFFF, 4'b0100};
        tbl[6] = '{2, 7,  1, 0, 0, 4'd0, 1, 1, 6,  32'hFFF,   4'b1100};
        tbl[7] = '{2, 1,  1, 0, 1, 4'd1, 0, 0, 1,  32'h3,     4'b1100};
        tbl[8] = '{0, 67, 1, 0, 0, 4'd0, 0, 0, 5,  32'h3E4,   4'b0000};
        tbl[9] = '{2, 8,  1, 0, 0, 4'd0, 1, 6, 2,  32'hF,     4'b1100};

        start_v = '0; refill_v = '0; ack_v = '0;
        change_v = '0; refill_sel_v = '0; refill_cnt_v = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy_v), 0);
        chk("rst_req", int'(coin_req_v), 0);
        chk("rst_done_fail", int'({done_v, fail_v}), 0);
        chk("rst_sel", int'(coin_sel_v), 0);
        chk("rst_remaining", int'(remaining_v), 0);
        chk("rst_empty_a", int'(empty_v[0]), 4'b0000);
        chk("rst_empty_b", int'(empty_v[1]), 4'b0001);
        chk("rst_empty_c", int'(empty_v[2]), 4'b0100);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                @(negedge clk);
                ack_v[0] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                ack_v[0] = 1'b0;
                chk("stray_ack_busy", int'(busy_v[0]), 0);
                chk("stray_ack_req", int'(coin_req_v[0]), 0);
                chk("stray_ack_rem", int'(remaining_v[0]), 0);
            end
            if (i == 5) begin
                do_refill(2, 2'd3, 4'd8);
                do_refill(2, 2'd3, 4'd14);
            end
            if (i == 8) begin
                @(negedge clk);
                start_v[0] = 1'b1;
                change_v[0] = 8'd67;
                @(posedge clk);
                @(negedge clk);
                start_v[0] = 1'b0;
                for (int k = 0; k < 10 && !coin_req_v[0]; k++) @(negedge clk);
                chk("mid_req_up", int'(coin_req_v[0]), 1);
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                chk("mid_rst_req", int'(coin_req_v[0]), 0);
                chk("mid_rst_busy", int'(busy_v[0]), 0);
                chk("mid_rst_rem", int'(remaining_v[0]), 0);
                chk("mid_rst_empty_c", int'(empty_v[2]), 4'b0100);
            end
            run_txn(tbl[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
